// File: rtl/shift_reg_sipo.sv
// rtl/shift_reg_sipo.sv - serial-in/parallel-out shift register with valid/ready word output (optional SHREG_PARITY_EN adds pout_par)
module shift_reg_sipo #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     msb_first,
  input  logic                     clear,
  output logic [WIDTH-1:0]         pout,
  output logic                     pout_valid,
  input  logic                     pout_ready,
  output logic                     sout,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     busy,
`ifdef SHREG_PARITY_EN
  output logic                     pout_par,
`endif
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             order_q, order_d;
  logic             sout_q, sout_d;
  logic             pout_valid_q, pout_valid_d;
  logic             overrun_q, overrun_d;
`ifdef SHREG_PARITY_EN
  logic             pout_par_q, pout_par_d;
`endif

  logic             accept;
  logic             cur_order;
  logic             complete;
  logic             displaced;
  logic [WIDTH-1:0] shifted;

  // Next-state: shifting, word completion, output handshake and clear
  always_comb begin
    accept    = sin_valid & ~clear;
    // The order is taken from msb_first only on the first bit of a word
    cur_order = (state_q == IDLE) ? msb_first : order_q;
    shifted   = cur_order ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
    displaced = cur_order ? shreg_q[WIDTH-1] : shreg_q[0];
    complete  = accept && (bit_cnt_q == LAST);

    state_d      = state_q;
    shreg_d      = shreg_q;
    pout_d       = pout_q;
    bit_cnt_d    = bit_cnt_q;
    order_d      = order_q;
    sout_d       = sout_q;
    pout_valid_d = pout_valid_q;
    overrun_d    = overrun_q;
`ifdef SHREG_PARITY_EN
    pout_par_d   = pout_par_q;
`endif

    if (pout_ready) begin
      pout_valid_d = 1'b0;
    end

    if (clear) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
      state_d   = IDLE;
      overrun_d = 1'b0;
    end else if (accept) begin
      shreg_d = shifted;
      sout_d  = displaced;
      order_d = cur_order;
      if (complete) begin
        bit_cnt_d = '0;
        state_d   = IDLE;
        // A finished word only replaces pout if the old one is gone or leaving now
        if (!pout_valid_q || pout_ready) begin
          pout_d       = shifted;
          pout_valid_d = 1'b1;
`ifdef SHREG_PARITY_EN
          pout_par_d   = ^shifted;
`endif
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        state_d   = SHIFT;
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      pout_q       <= '0;
      bit_cnt_q    <= '0;
      order_q      <= 1'b0;
      sout_q       <= 1'b0;
      pout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SHREG_PARITY_EN
      pout_par_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      pout_q       <= pout_d;
      bit_cnt_q    <= bit_cnt_d;
      order_q      <= order_d;
      sout_q       <= sout_d;
      pout_valid_q <= pout_valid_d;
      overrun_q    <= overrun_d;
`ifdef SHREG_PARITY_EN
      pout_par_q   <= pout_par_d;
`endif
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign sout       = sout_q;
  assign bit_cnt    = bit_cnt_q;
  assign busy       = (state_q == SHIFT);
  assign overrun    = overrun_q;
`ifdef SHREG_PARITY_EN
  assign pout_par   = pout_par_q;
`endif

endmodule

// File: tb/tb_shift_reg_sipo.sv
// tb/tb_shift_reg_sipo.sv - self-checking bench for shift_reg_sipo (WIDTH=8)
module tb_shift_reg_sipo;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         msb_first = 1'b1;
  logic         clear = 1'b0;
  logic [W-1:0] pout;
  logic         pout_valid;
  logic         pout_ready = 1'b1;
  logic         sout;
  logic [2:0]   bit_cnt;
  logic         busy;
  logic         overrun;
`ifdef SHREG_PARITY_EN
  logic         pout_par;
`endif

  int checks = 0;
  int errors = 0;

  shift_reg_sipo #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .msb_first  (msb_first),
    .clear      (clear),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .sout       (sout),
    .bit_cnt    (bit_cnt),
    .busy       (busy),
`ifdef SHREG_PARITY_EN
    .pout_par   (pout_par),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_bits[$];   // bits of the word in progress, in arrival order
  bit           m_hist[$];   // recently accepted bits, oldest first
  bit           m_order;
  bit           m_last_order;
  bit           m_zero;      // shift register known all-zero before m_hist
  bit           m_sout;
  bit           m_sout_known;
  logic [W-1:0] m_pout;
  bit           m_pv;
  bit           m_ov;
  bit           m_par;

  function automatic logic [W-1:0] assemble(input bit order);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (order) w[W-1-i] = m_bits[i];
      else       w[i]     = m_bits[i];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bits.delete(); m_hist.delete();
      m_zero = 1; m_sout = 0; m_sout_known = 1;
      m_pout = '0; m_pv = 0; m_ov = 0; m_par = 0;
    end else begin
      bit old_pv;
      logic [W-1:0] word;
      old_pv = m_pv;
      if (pout_ready) m_pv = 0;
      if (clear) begin
        m_bits.delete(); m_hist.delete();
        m_zero = 1; m_ov = 0;
      end else if (sin_valid) begin
        if (m_bits.size() == 0) begin
          m_order = msb_first;
          if (m_hist.size() > 0 && m_order != m_last_order) begin
            m_hist.delete();
            m_zero = 0;
          end
          m_last_order = m_order;
        end
        m_bits.push_back(sin);
        m_hist.push_back(sin);
        if (m_hist.size() > W) begin
          m_sout = m_hist.pop_front();
          m_sout_known = 1;
        end else begin
          m_sout = 0;
          m_sout_known = m_zero;
        end
        if (m_bits.size() == W) begin
          word = assemble(m_order);
          if (!old_pv || pout_ready) begin
            m_pout = word; m_pv = 1; m_par = ^word;
          end else begin
            m_ov = 1;
          end
          m_bits.delete();
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge
  always @(negedge clk) begin
    check("pout", 32'(pout), 32'(m_pout));
    check("pout_valid", 32'(pout_valid), 32'(m_pv));
    check("overrun", 32'(overrun), 32'(m_ov));
    check("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
    check("busy", 32'(busy), 32'(m_bits.size() > 0));
    if (m_sout_known) check("sout", 32'(sout), 32'(m_sout));
`ifdef SHREG_PARITY_EN
    check("pout_par", 32'(pout_par), 32'(m_par));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit order, input int gap,
                           input int toggle_at, input bit rdy_last);
    logic [W-1:0] wv;
    wv = w;
    for (int i = 0; i < W; i++) begin
      msb_first = (i >= toggle_at) ? ~order : order;
      sin       = order ? wv[W-1-i] : wv[i];
      sin_valid = 1'b1;
      if (rdy_last && i == W-1) pout_ready = 1'b1;
      tick();
      if (rdy_last && i == W-1) pout_ready = 1'b0;
      sin_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        sin = ~sin;
        tick();
      end
    end
    msb_first = order;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    tick(); tick();
    check("rst_pout", 32'(pout), 32'h0);
    check("rst_pv", 32'(pout_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    tick();

    // three bits then asynchronous reset mid-word
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1; sin_valid = 1'b1; tick();
    end
    sin_valid = 1'b0;
    check("pre_rst_cnt", 32'(bit_cnt), 32'd3);
    #1 rst = 1'b0;
    #1;
    check("async_rst_cnt", 32'(bit_cnt), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_sout", 32'(sout), 32'd0);
    check("async_rst_ov", 32'(overrun), 32'd0);
    #1 rst = 1'b1;
    tick();

    // MSB-first word
    send_word(8'b1011_0010, 1'b1, 0, W, 1'b0);
    check("msb_pout", 32'(pout), 32'hB2);
    check("msb_pv", 32'(pout_valid), 32'h1);
    check("model_msb", 32'(m_pout), 32'hB2);
`ifdef SHREG_PARITY_EN
    check("par_b2", 32'(pout_par), 32'h0);
`endif

    // LSB-first word, then msb_first toggled after bit 2
    send_word(8'h4D, 1'b0, 0, W, 1'b0);
    check("lsb_pout", 32'(pout), 32'h4D);
    check("model_lsb", 32'(m_pout), 32'h4D);
`ifdef SHREG_PARITY_EN
    check("par_4d", 32'(pout_par), 32'h0);
`endif
    send_word(8'h4D, 1'b0, 0, 2, 1'b0);
    check("toggle_pout", 32'(pout), 32'h4D);

    // gaps, and chaining through sout
    send_word(8'h0F, 1'b1, 1, W, 1'b0);
    check("gap_pout0", 32'(pout), 32'h0F);
    send_word(8'hB2, 1'b1, 2, W, 1'b0);
    check("gap_pout1", 32'(pout), 32'hB2);
    check("chain_sout", 32'(sout), 32'h1);

    // backpressure: two words without ready
    pout_ready = 1'b0;
    tick();
    send_word(8'hB2, 1'b1, 0, W, 1'b0);
    send_word(8'h0F, 1'b1, 0, W, 1'b0);
    check("bp_pout", 32'(pout), 32'hB2);
    check("bp_pv", 32'(pout_valid), 32'h1);
    check("bp_ov", 32'(overrun), 32'h1);

    // clear after 5 bits, together with sin_valid
    for (int i = 0; i < 5; i++) begin
      sin = 1'b1; sin_valid = 1'b1; tick();
    end
    clear = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    tick();
    clear = 1'b0; sin_valid = 1'b0;
    check("clr_cnt", 32'(bit_cnt), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_ov", 32'(overrun), 32'h0);
    check("clr_pout", 32'(pout), 32'hB2);

    // ready on the completion edge replaces the held word
    send_word(8'h0F, 1'b1, 0, W, 1'b1);
    check("rdy_pout", 32'(pout), 32'h0F);
    check("rdy_pv", 32'(pout_valid), 32'h1);
    check("rdy_ov", 32'(overrun), 32'h0);

    // odd-parity word
    pout_ready = 1'b1;
    send_word(8'h07, 1'b1, 0, W, 1'b0);
    check("w07_pout", 32'(pout), 32'h07);
`ifdef SHREG_PARITY_EN
    check("par_07", 32'(pout_par), 32'h1);
`endif
    tick(); tick();
    check("drain_pv", 32'(pout_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
